// File: rtl/calc_pkg.sv
// Shared constants for the stack calculator: opcodes, error codes, default
// stack geometry (also used by picture_generator) and the MUL FSM state type.
package calc_pkg;

    localparam int CALC_WIDTH = 16;
    localparam int CALC_DEPTH = 24;

    localparam logic [2:0] OP_PUSH  = 3'd0;
    localparam logic [2:0] OP_POP   = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_MUL   = 3'd4;
    localparam logic [2:0] OP_DUP   = 3'd5;
    localparam logic [2:0] OP_SWAP  = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_OVF  = 2'd1;
    localparam logic [1:0] ERR_UNF  = 2'd2;
    localparam logic [1:0] ERR_ILL  = 2'd3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier producing the low WIDTH bits of a*b.
// A start pulse loads the operands; WIDTH clock edges later the last
// iteration is presented combinationally on product together with done,
// so the caller can capture the result on that same edge.
module seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_step;
    logic [CW-1:0]    count;
    logic             busy;

    assign acc_step = acc + (mplier[0] ? mcand : '0);
    assign done     = busy && (count == CW'(WIDTH - 1));
    assign product  = acc_step;

    // Load operands on start, then one shift-add iteration per edge while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy  <= 1'b0;
            count <= '0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/calc_stack.sv
// Operand stack and ALU of the stack calculator. Shift-register stack whose
// registers are presented directly on numbers (TOS in the lowest word).
// Build option CALC_MUL_EN: when defined, opcode MUL runs on a WIDTH-cycle
// sequential multiplier and cmd_ready drops while it works; when undefined,
// MUL is rejected as an illegal op and cmd_ready is tied high.
module calc_stack
    import calc_pkg::*;
#(
    parameter int               WIDTH      = CALC_WIDTH,
    parameter int               DEPTH      = CALC_DEPTH,
    parameter logic [WIDTH-1:0] EMPTY_WORD = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [WIDTH-1:0]       cmd_data,
    output logic [4:0]             depth,
    output logic [DEPTH*WIDTH-1:0] numbers,
    output logic                   err_pulse,
    output logic [1:0]             err_code
);

    localparam logic [4:0] FULL = 5'(DEPTH);

    logic [WIDTH-1:0] stack     [DEPTH];
    logic [WIDTH-1:0] stack_nxt [DEPTH];
    logic [WIDTH-1:0] shift_up  [DEPTH];
    logic [WIDTH-1:0] shift_dn  [DEPTH];
    logic [4:0]       depth_nxt;
    logic [1:0]       code_nxt;
    logic [1:0]       bad;
    logic             pulse_nxt;
    logic             start_mul;
    logic             accept;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign accept = cmd_valid & cmd_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign numbers[g*WIDTH +: WIDTH] = stack[g];
    end

`ifdef CALC_MUL_EN
    fsm_state_t state;

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (start_mul),
        .a       (stack[1]),
        .b       (stack[0]),
        .done    (mul_done),
        .product (mul_product)
    );

    // IDLE/MUL sequencing; cmd_ready is registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
        end else begin
            case (state)
                S_IDLE: if (start_mul) begin
                    state     <= S_MUL;
                    cmd_ready <= 1'b0;
                end
                S_MUL: if (mul_done) begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end
`else
    assign cmd_ready   = 1'b1;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    // Candidate stack images for push-style and pop-style commands.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            shift_dn[i]     = stack[i+1];
            shift_up[i + 1] = stack[i];
        end
        shift_dn[DEPTH-1] = EMPTY_WORD;
        shift_up[0]       = cmd_data;
    end

    // Legality check and next stack / depth / error state for this cycle.
    always_comb begin
        stack_nxt = stack;
        depth_nxt = depth;
        code_nxt  = err_code;
        pulse_nxt = 1'b0;
        start_mul = 1'b0;
        bad       = ERR_NONE;
        if (mul_done) begin
            stack_nxt    = shift_dn;
            stack_nxt[0] = mul_product;
            depth_nxt    = depth - 5'd1;
        end else if (accept) begin
            case (cmd_op)
                OP_PUSH: if (depth == FULL) bad = ERR_OVF;
                OP_DUP: begin
                    if (depth == 5'd0)      bad = ERR_UNF;
                    else if (depth == FULL) bad = ERR_OVF;
                end
                OP_POP:                  if (depth == 5'd0) bad = ERR_UNF;
                OP_SWAP, OP_ADD, OP_SUB: if (depth < 5'd2)  bad = ERR_UNF;
`ifdef CALC_MUL_EN
                OP_MUL:                  if (depth < 5'd2)  bad = ERR_UNF;
`else
                OP_MUL:                  bad = ERR_ILL;
`endif
                default: bad = ERR_NONE;
            endcase

            if (bad != ERR_NONE) begin
                pulse_nxt = 1'b1;
                code_nxt  = bad;
            end else begin
                code_nxt = ERR_NONE;
                case (cmd_op)
                    OP_PUSH: begin
                        stack_nxt = shift_up;
                        depth_nxt = depth + 5'd1;
                    end
                    OP_DUP: begin
                        stack_nxt    = shift_up;
                        stack_nxt[0] = stack[0];
                        depth_nxt    = depth + 5'd1;
                    end
                    OP_POP: begin
                        stack_nxt = shift_dn;
                        depth_nxt = depth - 5'd1;
                    end
                    OP_SWAP: begin
                        stack_nxt[0] = stack[1];
                        stack_nxt[1] = stack[0];
                    end
                    OP_ADD: begin
                        stack_nxt    = shift_dn;
                        stack_nxt[0] = stack[1] + stack[0];
                        depth_nxt    = depth - 5'd1;
                    end
                    OP_SUB: begin
                        stack_nxt    = shift_dn;
                        stack_nxt[0] = stack[1] - stack[0];
                        depth_nxt    = depth - 5'd1;
                    end
                    OP_MUL: begin
`ifdef CALC_MUL_EN
                        start_mul = 1'b1;
`endif
                    end
                    OP_CLEAR: begin
                        for (int i = 0; i < DEPTH; i++) stack_nxt[i] = EMPTY_WORD;
                        depth_nxt = 5'd0;
                    end
                    default: depth_nxt = depth;
                endcase
            end
        end
    end

    // Stack registers, occupancy and error reporting.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stack[i] <= EMPTY_WORD;
            depth     <= 5'd0;
            err_pulse <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            stack     <= stack_nxt;
            depth     <= depth_nxt;
            err_pulse <= pulse_nxt;
            err_code  <= code_nxt;
        end
    end

endmodule

// File: tb/tb_calc_stack.sv
// Directed testbench for calc_stack: a table of single-cycle commands with
// hand-computed results, plus sequences for full stack, MUL timing and
// reset during MUL (or illegal MUL when CALC_MUL_EN is not defined).
module tb_calc_stack;
    import calc_pkg::*;

    localparam int W = 16;
    localparam int D = 24;

    logic           clk = 1'b0;
    logic           reset;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [2:0]     cmd_op;
    logic [W-1:0]   cmd_data;
    logic [4:0]     depth;
    logic [D*W-1:0] numbers;
    logic           err_pulse;
    logic [1:0]     err_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    calc_stack #(.WIDTH(W), .DEPTH(D), .EMPTY_WORD(16'h0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .depth     (depth),
        .numbers   (numbers),
        .err_pulse (err_pulse),
        .err_code  (err_code)
    );

    typedef struct {
        logic [2:0]  op;
        logic [15:0] data;
        logic [4:0]  d;
        logic [15:0] tos;
        logic [15:0] nos;
        logic        pulse;
        logic [1:0]  code;
    } vec_t;

    vec_t vecs [20];

    function automatic logic [W-1:0] slot(input int i);
        return numbers[W*i +: W];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_slots(input string tag, input int from, input logic [15:0] val);
        for (int i = from; i < D; i++) check($sformatf("%s slot%0d", tag, i), 32'(slot(i)), 32'(val));
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [15:0] d);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    initial begin
        int low;

        vecs[0]  = '{OP_PUSH,  16'h0012, 5'd1, 16'h0012, 16'h0000, 1'b0, ERR_NONE};
        vecs[1]  = '{OP_PUSH,  16'h0034, 5'd2, 16'h0034, 16'h0012, 1'b0, ERR_NONE};
        vecs[2]  = '{OP_ADD,   16'h0000, 5'd1, 16'h0046, 16'h0000, 1'b0, ERR_NONE};
        vecs[3]  = '{OP_PUSH,  16'h0005, 5'd2, 16'h0005, 16'h0046, 1'b0, ERR_NONE};
        vecs[4]  = '{OP_PUSH,  16'h0009, 5'd3, 16'h0009, 16'h0005, 1'b0, ERR_NONE};
        vecs[5]  = '{OP_SUB,   16'h0000, 5'd2, 16'hFFFC, 16'h0046, 1'b0, ERR_NONE};
        vecs[6]  = '{OP_POP,   16'h0000, 5'd1, 16'h0046, 16'h0000, 1'b0, ERR_NONE};
        vecs[7]  = '{OP_SWAP,  16'h0000, 5'd1, 16'h0046, 16'h0000, 1'b1, ERR_UNF};
        vecs[8]  = '{OP_DUP,   16'h0000, 5'd2, 16'h0046, 16'h0046, 1'b0, ERR_NONE};
        vecs[9]  = '{OP_PUSH,  16'h0007, 5'd3, 16'h0007, 16'h0046, 1'b0, ERR_NONE};
        vecs[10] = '{OP_SWAP,  16'h0000, 5'd3, 16'h0046, 16'h0007, 1'b0, ERR_NONE};
        vecs[11] = '{OP_POP,   16'h0000, 5'd2, 16'h0007, 16'h0046, 1'b0, ERR_NONE};
        vecs[12] = '{OP_CLEAR, 16'h0000, 5'd0, 16'h0000, 16'h0000, 1'b0, ERR_NONE};
        vecs[13] = '{OP_POP,   16'h0000, 5'd0, 16'h0000, 16'h0000, 1'b1, ERR_UNF};
        vecs[14] = '{OP_DUP,   16'h0000, 5'd0, 16'h0000, 16'h0000, 1'b1, ERR_UNF};
        vecs[15] = '{OP_ADD,   16'h0000, 5'd0, 16'h0000, 16'h0000, 1'b1, ERR_UNF};
        vecs[16] = '{OP_PUSH,  16'hFFFF, 5'd1, 16'hFFFF, 16'h0000, 1'b0, ERR_NONE};
        vecs[17] = '{OP_PUSH,  16'h0001, 5'd2, 16'h0001, 16'hFFFF, 1'b0, ERR_NONE};
        vecs[18] = '{OP_ADD,   16'h0000, 5'd1, 16'h0000, 16'h0000, 1'b0, ERR_NONE};
        vecs[19] = '{OP_SUB,   16'h0000, 5'd1, 16'h0000, 16'h0000, 1'b1, ERR_UNF};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset depth", 32'(depth), 0);
        check("reset ready", 32'(cmd_ready), 1);
        check("reset pulse", 32'(err_pulse), 0);
        check("reset code", 32'(err_code), 0);
        check_all_slots("reset", 0, 16'h0000);

        // Single-cycle command table
        for (int v = 0; v < 20; v++) begin
            issue(vecs[v].op, vecs[v].data);
            check($sformatf("vec%0d depth", v), 32'(depth), 32'(vecs[v].d));
            check($sformatf("vec%0d tos", v), 32'(slot(0)), 32'(vecs[v].tos));
            check($sformatf("vec%0d nos", v), 32'(slot(1)), 32'(vecs[v].nos));
            check($sformatf("vec%0d pulse", v), 32'(err_pulse), 32'(vecs[v].pulse));
            check($sformatf("vec%0d code", v), 32'(err_code), 32'(vecs[v].code));
            check_all_slots($sformatf("vec%0d empty", v), int'(vecs[v].d), 16'h0000);
        end

        // Fill to capacity, overflow, then clear
        issue(OP_CLEAR, 16'h0000);
        for (int i = 0; i < D; i++) issue(OP_PUSH, 16'h1904);
        check("full depth", 32'(depth), 24);
        check("full code", 32'(err_code), 0);
        issue(OP_PUSH, 16'hBEEF);
        check("ovf pulse", 32'(err_pulse), 1);
        check("ovf code", 32'(err_code), 1);
        check("ovf depth", 32'(depth), 24);
        check_all_slots("ovf", 0, 16'h1904);
        @(posedge clk);
        #1;
        check("ovf pulse drop", 32'(err_pulse), 0);
        check("ovf code hold", 32'(err_code), 1);
        issue(OP_DUP, 16'h0000);
        check("dup full code", 32'(err_code), 1);
        check("dup full pulse", 32'(err_pulse), 1);
        check("dup full depth", 32'(depth), 24);
        issue(OP_CLEAR, 16'h0000);
        check("clear depth", 32'(depth), 0);
        check("clear code", 32'(err_code), 0);
        check("clear pulse", 32'(err_pulse), 0);
        check_all_slots("clear", 0, 16'h0000);

`ifdef CALC_MUL_EN
        // MUL timing, with a PUSH held valid across the busy window
        issue(OP_PUSH, 16'h0100);
        issue(OP_PUSH, 16'h0203);
        issue(OP_MUL, 16'h0000);
        check("mul accept code", 32'(err_code), 0);
        cmd_valid = 1'b1;
        cmd_op    = OP_PUSH;
        cmd_data  = 16'h00AA;
        low = 0;
        while (cmd_ready == 1'b0 && low < 100) begin
            low++;
            if (slot(0) !== 16'h0203 || depth !== 5'd2)
                check("mul frozen", {11'd0, depth, slot(0)}, {11'd0, 5'd2, 16'h0203});
            @(posedge clk);
            #1;
        end
        check("mul ready low cycles", 32'(low), 16);
        check("mul tos", 32'(slot(0)), 32'h0300);
        check("mul depth", 32'(depth), 1);
        check_all_slots("mul empty", 1, 16'h0000);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("held push depth", 32'(depth), 2);
        check("held push tos", 32'(slot(0)), 32'h00AA);
        check("held push nos", 32'(slot(1)), 32'h0300);
        @(posedge clk);
        #1;
        check("held push once", 32'(depth), 2);

        // MUL with too few operands
        issue(OP_POP, 16'h0000);
        issue(OP_MUL, 16'h0000);
        check("mul unf code", 32'(err_code), 2);
        check("mul unf pulse", 32'(err_pulse), 1);
        check("mul unf ready", 32'(cmd_ready), 1);
        check("mul unf depth", 32'(depth), 1);

        // Reset in the middle of a MUL
        issue(OP_PUSH, 16'h0003);
        issue(OP_MUL, 16'h0000);
        check("mul2 busy", 32'(cmd_ready), 0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mul rst depth", 32'(depth), 0);
        check("mul rst ready", 32'(cmd_ready), 1);
        check_all_slots("mul rst", 0, 16'h0000);
        repeat (20) @(posedge clk);
        #1;
        check("mul rst no write depth", 32'(depth), 0);
        check("mul rst no write tos", 32'(slot(0)), 0);
`else
        // MUL is an illegal opcode in this build
        issue(OP_PUSH, 16'h0002);
        issue(OP_PUSH, 16'h0003);
        issue(OP_MUL, 16'h0000);
        check("ill code", 32'(err_code), 3);
        check("ill pulse", 32'(err_pulse), 1);
        check("ill depth", 32'(depth), 2);
        check("ill tos", 32'(slot(0)), 32'h0003);
        check("ill nos", 32'(slot(1)), 32'h0002);
        check("ill ready", 32'(cmd_ready), 1);
        @(posedge clk);
        #1;
        check("ill ready after", 32'(cmd_ready), 1);
        check("ill pulse drop", 32'(err_pulse), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
